shift_reg_engine: RTL and testbench



---
 rtl/shift_reg_engine.sv | 100 ++++++++++
 tb/tb_shift_reg_engine.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_engine.sv
// Parallel-load register that shifts/rotates left or right by a programmed amount, one position per clock.
// Start-to-done latency is amount+1 edges (1 edge for amount=0); load/start are ignored while busy.
module shift_reg_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] amount_i,
  input  logic             dir_i,
  input  logic             rotate_i,
  input  logic             ser_in_i,
  output logic [WIDTH-1:0] q_o,
  output logic             ser_out_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ser_q, ser_d;
  logic               done_q, done_d;
  logic               dir_q, dir_d;
  logic               rot_q, rot_d;
  logic               out_bit;
  logic               fill;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      ser_q   <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
    end
  end

  // Expelled bit and fill bit depend only on the direction/mode latched at start.
  assign out_bit = dir_q ? q_q[WIDTH-1] : q_q[0];
  assign fill    = rot_q ? out_bit : ser_in_i;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    ser_d   = ser_q;
    done_d  = 1'b0;
    dir_d   = dir_q;
    rot_d   = rot_q;
    case (state_q)
      IDLE: begin
        if (load_i) begin
          q_d = d_i;
        end else if (start_i) begin
          if (amount_i != '0) begin
            cnt_d   = amount_i;
            dir_d   = dir_i;
            rot_d   = rotate_i;
            state_d = SHIFT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (dir_q) q_d = {q_q[WIDTH-2:0], fill};
        else       q_d = {fill, q_q[WIDTH-1:1]};
        ser_d = out_bit;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign q_o       = q_q;
  assign ser_out_o = ser_q;
  assign busy_o    = (state_q == SHIFT);
  assign done_o    = done_q;

endmodule

// File: tb/tb_shift_reg_engine.sv
// Bench for shift_reg_engine: vector table, randomized ops against a transaction-level model, hand corner cases.
module tb_shift_reg_engine;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       load_i = 1'b0;
  logic [7:0] d_i = '0;
  logic       start_i = 1'b0;
  logic [3:0] amount_i = '0;
  logic       dir_i = 1'b0;
  logic       rotate_i = 1'b0;
  logic       ser_in_i = 1'b0;
  logic [7:0] q_o;
  logic       ser_out_o, busy_o, done_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic fills [0:15];
  logic ser_model = 1'b0;

  always #5 clk = ~clk;

  shift_reg_engine #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .load_i(load_i), .d_i(d_i), .start_i(start_i),
    .amount_i(amount_i), .dir_i(dir_i), .rotate_i(rotate_i), .ser_in_i(ser_in_i),
    .q_o(q_o), .ser_out_o(ser_out_o), .busy_o(busy_o), .done_o(done_o)
  );

  typedef struct {
    logic [7:0] d;
    int         amt;
    bit         dr;
    bit         rt;
    logic       sin;
    logic [7:0] exp_q;
    logic       exp_ser;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load_i = 1'b1; d_i = v;
    tick();
    load_i = 1'b0;
  endtask

  // Starts an op, drives ser_in from fills[] on each shift edge, waits (bounded) for done.
  task automatic do_op(input int amt, input bit dr, input bit rt,
                       output int bcnt, output int edges, output logic busy_at_done);
    start_i = 1'b1; amount_i = amt[3:0]; dir_i = dr; rotate_i = rt;
    tick();
    start_i = 1'b0;
    amount_i = 4'($urandom); dir_i = 1'($urandom); rotate_i = 1'($urandom);
    edges = 1; bcnt = 0;
    while (!done_o && edges < 40) begin
      if (busy_o) bcnt++;
      ser_in_i = fills[(edges - 1) & 15];
      tick();
      edges++;
    end
    busy_at_done = busy_o;
  endtask

  // Transaction-level model: rotates via a doubled word, shifts via integer arithmetic.
  function automatic void ref_op(input logic [7:0] v, input int n, input bit dr, input bit rt,
                                 input logic ser_prev, output logic [7:0] qo, output logic so);
    logic [15:0] t;
    int w;
    qo = v; so = ser_prev;
    if (n == 0) return;
    if (rt) begin
      if (dr) begin
        t = {v, v} << (n % 8); qo = t[15:8]; so = qo[0];
      end else begin
        t = {v, v} >> (n % 8); qo = t[7:0]; so = qo[7];
      end
    end else begin
      w = int'(v);
      for (int i = 0; i < n; i++) begin
        if (dr) begin
          so = 1'((w >> 7) & 1); w = ((w * 2) % 256) + int'(fills[i]);
        end else begin
          so = 1'(w & 1); w = (w / 2) + 128 * int'(fills[i]);
        end
      end
      qo = 8'(w);
    end
  endfunction

  initial begin
    vec_t vecs [8];
    int bcnt, edges, seen_busy, seen_done;
    logic bad;
    logic [7:0] eq, v;
    logic es;
    int amt;
    bit dr, rt;

    vecs[0] = '{8'hA5, 3,  0, 0, 1'b1, 8'hF4, 1'b1};
    vecs[1] = '{8'h81, 1,  1, 1, 1'b0, 8'h03, 1'b1};
    vecs[2] = '{8'h81, 8,  1, 1, 1'b0, 8'h81, 1'b1};
    vecs[3] = '{8'h3C, 4,  1, 0, 1'b0, 8'hC0, 1'b1};
    vecs[4] = '{8'hF0, 9,  0, 1, 1'b0, 8'h78, 1'b0};
    vecs[5] = '{8'h77, 0,  0, 0, 1'b1, 8'h77, 1'b0};
    vecs[6] = '{8'h5A, 15, 0, 0, 1'b0, 8'h00, 1'b0};
    vecs[7] = '{8'h0F, 5,  1, 0, 1'b1, 8'hFF, 1'b1};

    // Reset state, then reset aborting a 5-shift operation between edges
    repeat (3) tick();
    reset_n = 1'b1;
    check("rst_q", q_o, 0); check("rst_ser", ser_out_o, 0);
    check("rst_busy", busy_o, 0); check("rst_done", done_o, 0);
    for (int i = 0; i < 16; i++) fills[i] = 1'b1;
    do_load(8'hFF);
    start_i = 1'b1; amount_i = 4'd5; dir_i = 1'b0; rotate_i = 1'b0;
    tick(); start_i = 1'b0;
    tick(); tick();
    check("mid_busy", busy_o, 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_q", q_o, 0); check("arst_ser", ser_out_o, 0);
    check("arst_busy", busy_o, 0); check("arst_done", done_o, 0);
    tick(); reset_n = 1'b1;
    seen_busy = 0; seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (busy_o) seen_busy++;
      if (done_o) seen_done++;
    end
    check("post_rst_busy", seen_busy, 0); check("post_rst_done", seen_done, 0);
    ser_model = 1'b0;

    // Vector table
    foreach (vecs[i]) begin
      for (int j = 0; j < 16; j++) fills[j] = vecs[i].sin;
      do_load(vecs[i].d);
      check($sformatf("v%0d_load", i), q_o, vecs[i].d);
      do_op(vecs[i].amt, vecs[i].dr, vecs[i].rt, bcnt, edges, bad);
      check($sformatf("v%0d_lat", i), edges, vecs[i].amt + 1);
      check($sformatf("v%0d_busy", i), bcnt, vecs[i].amt);
      check($sformatf("v%0d_busy_at_done", i), bad, 0);
      check($sformatf("v%0d_q", i), q_o, vecs[i].exp_q);
      check($sformatf("v%0d_ser", i), ser_out_o, vecs[i].exp_ser);
      tick();
      check($sformatf("v%0d_done_pulse", i), done_o, 0);
      ser_model = vecs[i].exp_ser;
    end

    // Randomized ops against the model
    for (int it = 0; it < 40; it++) begin
      v = 8'($urandom); amt = $urandom_range(0, 15);
      dr = 1'($urandom); rt = 1'($urandom);
      for (int j = 0; j < 16; j++) fills[j] = 1'($urandom);
      ref_op(v, amt, dr, rt, ser_model, eq, es);
      do_load(v);
      do_op(amt, dr, rt, bcnt, edges, bad);
      check($sformatf("r%0d_lat", it), edges, amt + 1);
      check($sformatf("r%0d_busy", it), bcnt, amt);
      check($sformatf("r%0d_q", it), q_o, eq);
      check($sformatf("r%0d_ser", it), ser_out_o, es);
      ser_model = es;
    end

    // load wins over simultaneous start
    load_i = 1'b1; d_i = 8'h3C; start_i = 1'b1; amount_i = 4'd2;
    tick();
    load_i = 1'b0; start_i = 1'b0;
    check("prio_q", q_o, 8'h3C); check("prio_busy", busy_o, 0); check("prio_done", done_o, 0);
    tick();
    check("prio_busy2", busy_o, 0); check("prio_done2", done_o, 0);

    // load during SHIFT is ignored
    for (int j = 0; j < 16; j++) fills[j] = 1'b1;
    do_load(8'hA5);
    start_i = 1'b1; amount_i = 4'd3; dir_i = 1'b0; rotate_i = 1'b0; ser_in_i = 1'b1;
    tick(); start_i = 1'b0;
    load_i = 1'b1; d_i = 8'hFF;
    tick(); check("ign_q1", q_o, 8'hD2);
    tick(); check("ign_q2", q_o, 8'hE9);
    tick(); check("ign_q3", q_o, 8'hF4);
    check("ign_done", done_o, 1); check("ign_ser", ser_out_o, 1);
    load_i = 1'b0;
    tick();

    // Back-to-back: second start issued in the done cycle of the first
    for (int j = 0; j < 16; j++) fills[j] = 1'b0;
    do_load(8'h11);
    start_i = 1'b1; amount_i = 4'd1; dir_i = 1'b0; rotate_i = 1'b0; ser_in_i = 1'b0;
    tick(); start_i = 1'b0;
    edges = 0;
    while (!done_o && edges < 20) begin tick(); edges++; end
    check("b2b_first_done", done_o, 1);
    check("b2b_first_q", q_o, 8'h08);
    start_i = 1'b1; amount_i = 4'd2; dir_i = 1'b1; rotate_i = 1'b1;
    tick(); start_i = 1'b0;
    check("b2b_busy", busy_o, 1);
    edges = 1;
    while (!done_o && edges < 20) begin tick(); edges++; end
    check("b2b_lat", edges, 3);
    check("b2b_q", q_o, 8'h20);
    check("b2b_ser", ser_out_o, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
